// File: rtl/bus_reg_slave.sv
// Word-register slave behind a cs_/as_/rdy_ handshake: six scratch registers, a cycle counter and an ID.
// Optional wait states are compiled in with `define BUS_REG_SLAVE_WAIT_EN.
module bus_reg_slave #(
  parameter int unsigned WAIT     = 2,
  parameter logic [31:0] SLAVE_ID = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_,
  input  logic        as_,
  input  logic        rw,
  input  logic [2:0]  addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        rdy_
);
  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 3;
  localparam int unsigned NSCR = 6;
  localparam logic [AW-1:0] CNT_ADDR = AW'(6);
  localparam logic [AW-1:0] ID_ADDR  = AW'(7);

  if (WAIT > 15) begin : g_wait_range
    $error("bus_reg_slave: WAIT must be in 0..15");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] lat_addr;
  logic          lat_rw;
  logic [DW-1:0] lat_data;
  logic [DW-1:0] scratch [NSCR];
  logic [DW-1:0] cyc_cnt;
  logic          req_c;
  logic          commit_c;
  logic          acc_rw_c;
  logic [AW-1:0] acc_addr_c;
  logic [DW-1:0] acc_data_c;
  logic [DW-1:0] rd_mux_c;

`ifdef BUS_REG_SLAVE_WAIT_EN
  localparam int unsigned CW = 4;
  logic [CW-1:0] wait_cnt, wait_nxt;
`endif

  // A request is only seen in IDLE; on that edge the live inputs stand in for the latch.
  assign req_c      = (state == ST_IDLE) && !cs_ && !as_;
  assign acc_addr_c = req_c ? addr    : lat_addr;
  assign acc_rw_c   = req_c ? rw      : lat_rw;
  assign acc_data_c = req_c ? wr_data : lat_data;
  assign commit_c   = (state_nxt == ST_ACK);

  always_comb begin
    state_nxt = state;
`ifdef BUS_REG_SLAVE_WAIT_EN
    wait_nxt  = wait_cnt;
`endif
    case (state)
      ST_IDLE: begin
        if (req_c) begin
`ifdef BUS_REG_SLAVE_WAIT_EN
          if (WAIT == 0) begin
            state_nxt = ST_ACK;
          end else begin
            state_nxt = ST_WAIT;
            wait_nxt  = CW'(WAIT - 1);
          end
`else
          state_nxt = ST_ACK;
`endif
        end
      end
`ifdef BUS_REG_SLAVE_WAIT_EN
      ST_WAIT: begin
        if (cs_) begin
          state_nxt = ST_IDLE;
          wait_nxt  = '0;
        end else if (wait_cnt == '0) begin
          state_nxt = ST_ACK;
        end else begin
          wait_nxt  = wait_cnt - CW'(1);
        end
      end
`endif
      ST_ACK:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Register 6 reads the value it holds during the ACK cycle.
  always_comb begin
    rd_mux_c = '0;
    case (acc_addr_c)
      CNT_ADDR: rd_mux_c = cyc_cnt + DW'(1);
      ID_ADDR:  rd_mux_c = SLAVE_ID;
      default:  rd_mux_c = scratch[acc_addr_c];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      rdy_     <= 1'b1;
      rd_data  <= '0;
      lat_addr <= '0;
      lat_rw   <= 1'b0;
      lat_data <= '0;
    end else begin
      state   <= state_nxt;
      rdy_    <= !commit_c;
      rd_data <= (commit_c && acc_rw_c) ? rd_mux_c : '0;
      if (req_c) begin
        lat_addr <= addr;
        lat_rw   <= rw;
        lat_data <= wr_data;
      end
    end
  end

`ifdef BUS_REG_SLAVE_WAIT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt <= '0;
    else        wait_cnt <= wait_nxt;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSCR; i++) scratch[i] <= '0;
    end else if (commit_c && !acc_rw_c && (acc_addr_c < AW'(NSCR))) begin
      scratch[acc_addr_c] <= acc_data_c;
    end
  end

  // Free-running counter; a committed write takes priority over the increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                                cyc_cnt <= '0;
    else if (commit_c && !acc_rw_c && acc_addr_c == CNT_ADDR) cyc_cnt <= acc_data_c;
    else                                                       cyc_cnt <= cyc_cnt + DW'(1);
  end

endmodule

// File: doc/bus_reg_slave.md
BUS_REG_SLAVE -- requirements
Module: bus_reg_slave

Interface
REQ-001 SHALL have parameter: WAIT  2  wait cycles inserted before rdy_, range 0..15.
REQ-002 SHALL have parameter: SLAVE_ID  32'h0000_0000  constant returned by register 7.
REQ-003 SHALL have port: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port: cs_  in  1  chip select, active-low.
REQ-006 SHALL have port: as_  in  1  address strobe, active-low.
REQ-007 SHALL have port: rw  in  1  access direction, 1 = READ, 0 = WRITE.
REQ-008 SHALL have port: addr  in  3  word register index 0..7.
REQ-009 SHALL have port: wr_data  in  32  write data.
REQ-010 SHALL have port: rd_data  out  32  read data, valid only while rdy_ = 0.
REQ-011 SHALL have port: rdy_  out  1  access complete, active-low, registered.

Function
REQ-012 SHALL implement FSM states IDLE, WAIT, ACK.
REQ-013 SHALL accept a request only in IDLE, when cs_ = 0 and as_ = 0 at a rising edge, latching addr, rw and wr_data at that edge.
REQ-014 SHALL go from IDLE to ACK on request when WAIT = 0 or wait states are compiled out; otherwise to WAIT with the wait counter loaded to WAIT-1.
REQ-015 SHALL in WAIT decrement the counter each cycle and enter ACK on the edge where the counter is 0.
REQ-016 SHALL in WAIT return to IDLE with no rdy_ and no write if cs_ = 1 is sampled (abort).
REQ-017 SHALL drive rdy_ = 0 for exactly one cycle (state ACK), then return to IDLE unconditionally; cs_/as_ sampled in ACK are ignored.
REQ-018 SHALL treat as_ still low in the first IDLE cycle after ACK as a new access (back-to-back accesses: 1 idle cycle minimum between rdy_ pulses).
REQ-019 SHALL commit a write on the edge entering ACK, using latched addr/wr_data.
REQ-020 SHALL present read data from latched addr in the ACK cycle; rd_data SHALL be 32'h0 whenever rdy_ = 1.
REQ-021 SHALL map registers 0..5 as read/write 32-bit scratch registers.
REQ-022 SHALL map register 6 as a free-running cycle counter, +1 per clock, wrapping 32'hFFFF_FFFF -> 0; a write loads wr_data, write wins over increment, counting resumes from the loaded value next cycle.
REQ-023 SHALL map register 7 as read-only SLAVE_ID; writes complete normally (rdy_ pulsed) with no effect.
REQ-024 SHALL complete write accesses with rd_data = 32'h0 in the ACK cycle.

Reset
REQ-025 SHALL on reset = 0 immediately force state IDLE, wait counter 0, rdy_ = 1, rd_data = 32'h0, registers 0..6 = 32'h0, latched request cleared.
REQ-026 SHALL abandon an in-flight access on reset mid-operation with no write committed and no rdy_ after release.
REQ-027 SHALL resume counting and accept requests from the first rising edge after reset deasserts.

Configuration
REQ-028 SHALL honour macro BUS_REG_SLAVE_WAIT_EN: defined -> WAIT state and counter present, latency per REQ-014/015; undefined -> WAIT state and counter removed, WAIT ignored, rdy_ always one cycle after request edge.

Verification
REQ-029 SHALL cover: macro defined, WAIT=2, write 32'hDEAD_BEEF to reg 3, read reg 3 -> rdy_ low 3 cycles after each request edge, read returns 32'hDEAD_BEEF.
REQ-030 SHALL cover: macro undefined, read reg 7 with SLAVE_ID=32'h0000_00A5 -> rdy_ low in cycle after request, rd_data = 32'h0000_00A5; write reg 7 then read -> still 32'h0000_00A5.
REQ-031 SHALL cover: write 32'hFFFF_FFFE to reg 6 -> reads later show wrap through 32'hFFFF_FFFF to 32'h0000_0000 and continue incrementing.
REQ-032 SHALL cover: macro defined, WAIT=4, write reg 1 = 32'h1234_5678, cs_ raised after 2 cycles -> no rdy_, reg 1 reads 32'h0.
REQ-033 SHALL cover: reset asserted during WAIT of a write to reg 2 -> rdy_ = 1 and rd_data = 0 immediately, reg 2 reads 32'h0 after release.
REQ-034 SHALL cover: as_ held low across ACK -> exactly one rdy_ pulse per access, second access begins in the following IDLE cycle, rd_data = 0 whenever rdy_ = 1.
